// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline definitions: FSM states, register-specifier width, stage-control bundle.
// Pure declarations; no latency and no backpressure.
package pipe_ctrl_pkg;

    localparam int REG_W = 4;

    // Instruction word that a flushed pipeline register carries.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_IMISS = 2'd1,
        ST_DMISS = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    typedef struct packed {
        logic pc_we;
        logic ifid_we;
        logic ifid_flush;
        logic idex_we;
        logic idex_flush;
        logic exmem_we;
        logic memwb_we;
    } stage_ctl_t;

    localparam stage_ctl_t CTL_RUN = '{
        pc_we:      1'b1,
        ifid_we:    1'b1,
        ifid_flush: 1'b0,
        idex_we:    1'b1,
        idex_flush: 1'b0,
        exmem_we:   1'b1,
        memwb_we:   1'b1
    };

    localparam stage_ctl_t CTL_FROZEN = '0;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Condition inputs and stage-control outputs between the pipeline and its sequencer.
// Wires only; no latency and no backpressure.
interface pipe_ctrl_if #(parameter int CNT_W = 16);
    import pipe_ctrl_pkg::*;

    logic             idex_memread;
    logic [REG_W-1:0] idex_rd;
    logic [REG_W-1:0] ifid_rs;
    logic [REG_W-1:0] ifid_rt;
    logic             ifid_uses_rt;
    logic             ex_redirect;
    logic             icache_busy;
    logic             dcache_busy;
    logic             memwb_halt;

    logic             pc_we;
    logic             ifid_we;
    logic             ifid_flush;
    logic             idex_we;
    logic             idex_flush;
    logic             exmem_we;
    logic             memwb_we;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output idex_memread, idex_rd, ifid_rs, ifid_rt, ifid_uses_rt,
        output ex_redirect, icache_busy, dcache_busy, memwb_halt,
        input  pc_we, ifid_we, ifid_flush, idex_we, idex_flush,
        input  exmem_we, memwb_we, halted, stall_cnt
    );

    modport slave (
        input  idex_memread, idex_rd, ifid_rs, ifid_rt, ifid_uses_rt,
        input  ex_redirect, icache_busy, dcache_busy, memwb_halt,
        output pc_we, ifid_we, ifid_flush, idex_we, idex_flush,
        output exmem_we, memwb_we, halted, stall_cnt
    );

endinterface

// File: rtl/pipe_ctrl_hazard_unit.sv
// Load-to-use detector: EX load whose destination feeds the ID instruction.
// Combinational, zero latency; no backpressure.
module hazard_unit
    import pipe_ctrl_pkg::*;
(
    input  logic             idex_memread_i,
    input  logic [REG_W-1:0] idex_rd_i,
    input  logic [REG_W-1:0] ifid_rs_i,
    input  logic [REG_W-1:0] ifid_rt_i,
    input  logic             ifid_uses_rt_i,
    output logic             lu_o
);

    logic rs_hit;
    logic rt_hit;

    assign rs_hit = (idex_rd_i == ifid_rs_i);
    assign rt_hit = ifid_uses_rt_i & (idex_rd_i == ifid_rt_i);

    // r0 is hardwired zero, so a load into it never creates a dependency.
    assign lu_o = idex_memread_i & (idex_rd_i != '0) & (rs_hit | rt_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Central sequencer: per-stage write enables/flushes from hazards, misses, redirects and halt.
// Stage controls are combinational (zero latency); state, redirect_pend and stall_cnt update per clock.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
)
(
    input  logic       clk,
    input  logic       rst_n,
    pipe_ctrl_if.slave bus
);

    state_t           state_q;
    state_t           state_d;
    logic             redirect_pend_q;
    logic             redirect_pend_d;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;
    stage_ctl_t       ctl;
    logic             lu;

    hazard_unit u_hazard (
        .idex_memread_i (bus.idex_memread),
        .idex_rd_i      (bus.idex_rd),
        .ifid_rs_i      (bus.ifid_rs),
        .ifid_rt_i      (bus.ifid_rt),
        .ifid_uses_rt_i (bus.ifid_uses_rt),
        .lu_o           (lu)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_RUN;
            redirect_pend_q <= 1'b0;
            stall_cnt_q     <= '0;
        end else begin
            state_q         <= state_d;
            redirect_pend_q <= redirect_pend_d;
            stall_cnt_q     <= stall_cnt_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        redirect_pend_d = redirect_pend_q;
        stall_cnt_d     = stall_cnt_q;
        ctl             = CTL_RUN;

        if (state_q == ST_HALT) begin
            ctl = CTL_FROZEN;
        end else if (bus.dcache_busy) begin
            // The branch stays frozen in EX and redirects again later, so setting here is harmless.
            ctl     = CTL_FROZEN;
            state_d = ST_DMISS;
            if (bus.ex_redirect) begin
                redirect_pend_d = 1'b1;
            end
        end else begin
            if (bus.memwb_halt) begin
                state_d = ST_HALT;
            end else if (bus.icache_busy) begin
                state_d = ST_IMISS;
            end else begin
                state_d = ST_RUN;
            end

            if (bus.ex_redirect) begin
                ctl.ifid_flush  = 1'b1;
                ctl.idex_flush  = 1'b1;
                redirect_pend_d = bus.icache_busy;
            end else if (bus.icache_busy) begin
                ctl.pc_we      = 1'b0;
                ctl.ifid_flush = 1'b1;
            end else begin
                if (lu) begin
                    ctl.pc_we      = 1'b0;
                    ctl.ifid_we    = 1'b0;
                    ctl.idex_flush = 1'b1;
                end
                // First fetch return after a redirect-during-miss belongs to the old path.
                if (redirect_pend_q) begin
                    ctl.ifid_flush = 1'b1;
                end
                redirect_pend_d = 1'b0;
            end
        end

        if ((state_q != ST_HALT) && !ctl.pc_we && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    assign bus.pc_we      = ctl.pc_we    & rst_n;
    assign bus.ifid_we    = ctl.ifid_we  & rst_n;
    assign bus.idex_we    = ctl.idex_we  & rst_n;
    assign bus.exmem_we   = ctl.exmem_we & rst_n;
    assign bus.memwb_we   = ctl.memwb_we & rst_n;
    assign bus.ifid_flush = ctl.ifid_flush;
    assign bus.idex_flush = ctl.idex_flush;
    assign bus.halted     = (state_q == ST_HALT);
    assign bus.stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed scenarios plus random conditions against a rule-based model.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int CW     = 5;
    localparam int CNTMAX = (1 << CW) - 1;

    typedef struct {
        logic [7:0] ctl;   // {pc,ifid_we,ifid_flush,idex_we,idex_flush,exmem,memwb,halted}
        int         cnt;
        int         plan;  // independent stall_cnt value to confirm, or -1
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipe_ctrl_if #(.CNT_W(CW)) bus();

    pipe_ctrl #(.CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    bit   m_halted;
    bit   m_pend;
    int   m_cnt;

    task automatic drive(input bit mr, input int rd, input int rs, input int rt, input bit urt,
                         input bit redir, input bit ic, input bit dc, input bit hlt);
        bus.idex_memread = mr;
        bus.idex_rd      = rd[REG_W-1:0];
        bus.ifid_rs      = rs[REG_W-1:0];
        bus.ifid_rt      = rt[REG_W-1:0];
        bus.ifid_uses_rt = urt;
        bus.ex_redirect  = redir;
        bus.icache_busy  = ic;
        bus.dcache_busy  = dc;
        bus.memwb_halt   = hlt;
    endtask

    task automatic step(input bit mr, input int rd, input int rs, input int rt, input bit urt,
                        input bit redir, input bit ic, input bit dc, input bit hlt,
                        input int plan = -1);
        exp_t e;
        int   cause;
        bit   lu_m;
        int   rdv, rsv, rtv;
        @(posedge clk);
        #1;
        drive(mr, rd, rs, rt, urt, redir, ic, dc, hlt);
        rdv  = rd % 16;
        rsv  = rs % 16;
        rtv  = rt % 16;
        lu_m = mr && (rdv != 0) && ((rdv == rsv) || (urt && (rdv == rtv)));
        if (m_halted)   cause = 0;
        else if (dc)    cause = 1;
        else if (redir) cause = 2;
        else if (ic)    cause = 3;
        else if (lu_m)  cause = 4;
        else            cause = 5;
        case (cause)
            0:       e.ctl = 8'b0000_0001;
            1:       e.ctl = 8'b0000_0000;
            2:       e.ctl = 8'b1111_1110;
            3:       e.ctl = 8'b0111_0110;
            4:       e.ctl = {3'b000, 2'b11, 3'b110} | (m_pend ? 8'b0010_0000 : 8'b0);
            default: e.ctl = 8'b1101_0110 | (m_pend ? 8'b0010_0000 : 8'b0);
        endcase
        e.cnt  = m_cnt;
        e.plan = plan;
        exp_q.push_back(e);

        if (!m_halted) begin
            if ((cause == 1 || cause == 3 || cause == 4) && m_cnt < CNTMAX) m_cnt++;
            if (dc) begin
                if (redir) m_pend = 1'b1;
            end else begin
                if (redir)    m_pend = ic;
                else if (!ic) m_pend = 1'b0;
                if (hlt)      m_halted = 1'b1;
            end
        end
    endtask

    task automatic idle(input int plan = -1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, plan);
    endtask

    task automatic do_reset();
        exp_t e;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        m_halted = 1'b0;
        m_pend   = 1'b0;
        m_cnt    = 0;
        e.ctl    = 8'h00;
        e.cnt    = 0;
        e.plan   = 0;
        exp_q.push_back(e);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin : mon
        exp_t       e;
        logic [7:0] got;
        cyc++;
        if (exp_q.size() != 0) begin
            e   = exp_q.pop_front();
            got = {bus.pc_we, bus.ifid_we, bus.ifid_flush, bus.idex_we, bus.idex_flush,
                   bus.exmem_we, bus.memwb_we, bus.halted};
            total++;
            if (got !== e.ctl) begin
                bad++;
                $display("FAIL ctl cyc=%0d rst_n=%b got=%b want=%b", cyc, rst_n, got, e.ctl);
            end
            total++;
            if (int'(bus.stall_cnt) != e.cnt) begin
                bad++;
                $display("FAIL stall_cnt cyc=%0d got=%0d want=%0d", cyc, bus.stall_cnt, e.cnt);
            end
            if (e.plan >= 0) begin
                total++;
                if (int'(bus.stall_cnt) != e.plan) begin
                    bad++;
                    $display("FAIL plan_cnt cyc=%0d got=%0d want=%0d", cyc, bus.stall_cnt, e.plan);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: stimulus did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        m_halted = 1'b0;
        m_pend   = 1'b0;
        m_cnt    = 0;

        // Load-use on rs: one bubble.
        do_reset();
        step(1, 3, 3, 5, 0, 0, 0, 0, 0);
        idle(1);
        idle();

        // Non-hazards (rd = r0, unused rt), then a real rt hazard.
        do_reset();
        step(1, 0, 0, 0, 1, 0, 0, 0, 0);
        step(1, 3, 1, 3, 0, 0, 0, 0, 0);
        idle(0);
        step(1, 3, 1, 3, 1, 0, 0, 0, 0);
        idle(1);

        // D-miss for 4 cycles over a load-use, then the bubble.
        do_reset();
        repeat (4) step(1, 3, 3, 0, 0, 0, 0, 1, 0);
        step(1, 3, 3, 0, 0, 0, 0, 0, 0);
        idle(5);

        // Redirect during an I-miss; stale return flushed.
        do_reset();
        step(0, 0, 0, 0, 0, 1, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0, 0);
        idle();
        idle(2);

        // Redirect beats load-use.
        do_reset();
        step(1, 3, 3, 0, 0, 1, 0, 0, 0);
        idle(0);

        // Halt freezes everything, then reset mid-halt.
        do_reset();
        step(1, 2, 0, 2, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        repeat (3) step(1, 3, 3, 0, 0, 0, 1, 0, 0);
        idle(1);
        do_reset();
        idle(0);

        // Counter saturation.
        do_reset();
        repeat (CNTMAX + 4) step(0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(CNTMAX);

        // Random conditions.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if (i % 60 == 59) do_reset();
            step($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 1),
                 $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 39) == 0);
        end

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline sequencer for the 5-stage core.
- Combines four conditions into per-stage write-enable and flush controls:
  - load-to-use hazard (ID vs EX)
  - branch/jump redirect resolved in EX
  - instruction-cache miss
  - data-cache miss
- Tracks halt retirement and counts stall cycles for performance debug.
- Sits beside the pipeline registers and drives every PC, IF/ID, ID/EX, EX/MEM and MEM/WB enable.

Parameters:
- REG_W, 4, register-specifier width.
- CNT_W, 16, stall-counter width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- idex_memread  in  1  instruction in EX is a load
- idex_rd  in  REG_W  destination register of the EX instruction
- ifid_rs  in  REG_W  source 1 of the ID instruction
- ifid_rt  in  REG_W  source 2 of the ID instruction
- ifid_uses_rt  in  1  ID instruction actually reads rt
- ex_redirect  in  1  EX resolved a taken branch or jump (PC mispredicted)
- icache_busy  in  1  fetch not yet returned
- dcache_busy  in  1  MEM-stage access not yet complete
- memwb_halt  in  1  HLT instruction reaching WB
- pc_we  out  1  PC register write enable
- ifid_we  out  1  IF/ID write enable
- ifid_flush  out  1  load NOP into IF/ID
- idex_we  out  1  ID/EX write enable
- idex_flush  out  1  load NOP (bubble) into ID/EX
- exmem_we  out  1  EX/MEM write enable
- memwb_we  out  1  MEM/WB write enable
- halted  out  1  core stopped
- stall_cnt  out  CNT_W  cycles in which pc_we was 0 while not halted

Behaviour:
- State register: RUN, IMISS, DMISS, HALT. Reset state is RUN.
- Registered state: redirect_pend, stall_cnt.
- Reset values:
  - redirect_pend = 0, stall_cnt = 0, halted = 0.
  - All *_we = 1 and all *_flush = 0 once reset deasserts.
  - During reset (rst_n = 0), every *_we is forced to 0.
- The stage outputs below are combinational from state and inputs.
- Load-use term: lu = idex_memread & (idex_rd != 0) & ((idex_rd == ifid_rs) | (ifid_uses_rt & (idex_rd == ifid_rt))).
- Priority, highest first: HALT > dcache_busy > ex_redirect > icache_busy > lu.
- HALT state:
  - All *_we = 0, halted = 1.
  - Leaves HALT only via reset.
- dcache_busy = 1 (state DMISS):
  - Whole pipe frozen: every *_we = 0, no flushes.
  - redirect_pend is still set if ex_redirect = 1, because a branch in EX stays frozen, so this is idempotent.
  - Returns to RUN in the cycle after dcache_busy falls.
- ex_redirect = 1, dcache idle:
  - ifid_flush = 1, idex_flush = 1, all *_we = 1. The PC loads the target.
  - If icache_busy = 1 in the same cycle: pc_we = 1 is still asserted, the fetch restarts at the target, and redirect_pend is set.
  - redirect_pend forces ifid_flush on the cycle icache_busy falls, discarding a stale return. It clears after that cycle.
  - ex_redirect overrides lu in the same cycle: no lu stall.
- icache_busy = 1, no higher event (state IMISS):
  - pc_we = 0, ifid_we = 1 with ifid_flush = 1 (NOP enters ID).
  - Downstream continues: idex_we = exmem_we = memwb_we = 1.
- lu = 1, no higher event:
  - pc_we = 0, ifid_we = 0, idex_flush = 1 (one bubble). Downstream enables stay 1.
  - Lasts exactly 1 cycle, because the load then leaves EX.
- memwb_halt = 1 with dcache idle:
  - Enter HALT next edge. MEM/WB completes its write this cycle.
- stall_cnt:
  - Increments when pc_we = 0 and state != HALT.
  - Saturates at all-ones; it does not wrap.
- Reset mid-miss: asynchronous return to RUN, redirect_pend cleared.

Decomposition:
- Shared pipeline package holds:
  - state enum (RUN/IMISS/DMISS/HALT)
  - REG_W
  - the NOP encoding used by the flushed pipeline registers.
- The load-use comparator is a natural sub-module, hazard_unit (pure combinational, lu output).
- The FSM, priority mux and counter stay in pipe_ctrl.

Test Plan:
- Load r3 in EX, ID reads rs = r3 -> exactly 1 cycle with pc_we = 0, ifid_we = 0, idex_flush = 1; then all enables 1. stall_cnt = 1.
- Same case with idex_rd = 0, or ifid_uses_rt = 0 with a rt match -> no stall.
- dcache_busy held 4 cycles while a load-use condition is present -> all *_we = 0 for 4 cycles, then the 1-cycle lu bubble. stall_cnt = 5.
- ex_redirect with icache_busy = 1 for 3 cycles -> cycle 0 flushes IF/ID and ID/EX. ifid_flush stays 1 through the cycle icache_busy falls, then 0.
- ex_redirect and lu in the same cycle -> flushes only, pc_we = 1, no stall counted.
- memwb_halt -> halted = 1 next cycle, all *_we = 0, stall_cnt frozen. Asserting rst_n = 0 mid-halt clears state, with halted = 0 immediately.
